// File: rtl/rect_phys_pkg.sv
// Shared types and constants for the draggable-rectangle physics controller.
//   rect_state_t : controller mode (FOLLOW / FALL / RISE / REST)
//   pos_t        : integer pixel coordinate, 12 bits
//   ypos_fp_t    : fixed-point vertical position container. It is wide enough for a
//                  12-bit integer part, any FRAC_BITS up to 16, and headroom for adding
//                  a full-scale velocity without wrapping.
//   clamp_pos    : min() helper for pixel coordinates
package rect_phys_pkg;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        RISE   = 2'd2,
        REST   = 2'd3
    } rect_state_t;

    localparam int POS_W = 12;
    localparam int YFP_W = 32;

    localparam int SCREEN_W_DEF = 800;
    localparam int SCREEN_H_DEF = 600;
    localparam int RECT_W_DEF   = 48;
    localparam int RECT_H_DEF   = 64;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [YFP_W-1:0] ypos_fp_t;

    function automatic pos_t clamp_pos(input pos_t v, input pos_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rect_gravity_ctl_tick_gen.sv
// Free-running physics-tick prescaler.
//   i_clk  : clock
//   i_rst  : async active-high reset, clears the counter to 0
//   o_tick : high for exactly one cycle while the counter sits at DIV-1,
//            i.e. once every DIV cycles
module tick_gen #(
    parameter int DIV = 650000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/rect_gravity_ctl.sv
// Position controller for the draggable rectangle.
// While in FOLLOW the rectangle tracks the mouse, clamped so it stays on screen.
// A click (rising edge of the left button) drops it, and gravity then acts once per
// physics tick. On hitting the floor it bounces with its velocity halved, and it stops
// once the bounce is too weak. A click while airborne or resting grabs it back.
//   clk, rst           : clock, async active-high reset
//   mouse_left         : left button level (synchronous to clk)
//   mouse_x_position   : mouse x, px
//   mouse_y_position   : mouse y, px
//   xpos, ypos         : rectangle top-left corner, px
//   airborne           : high in FALL or RISE
//   dbg_state          : current controller state (rect_state_t encoding)
//   dbg_vel            : current velocity magnitude, FRAC units
module rect_gravity_ctl
    import rect_phys_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int RECT_W       = RECT_W_DEF,
    parameter int RECT_H       = RECT_H_DEF,
    parameter int FRAC_BITS    = 8,
    parameter int VEL_W        = 20,
    parameter int GRAVITY      = 64,
    parameter int TICK_DIV     = 650000,
    parameter int BOUNCE_SHIFT = 1,
    parameter int REST_VEL     = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mouse_left,
    input  logic [11:0]       mouse_x_position,
    input  logic [11:0]       mouse_y_position,
    output logic [11:0]       xpos,
    output logic [11:0]       ypos,
    output logic              airborne,
    output logic [1:0]        dbg_state,
    output logic [VEL_W-1:0]  dbg_vel
);

    localparam int FLOOR_PX = SCREEN_H - RECT_H;
    localparam int XMAX_PX  = SCREEN_W - RECT_W;

    localparam pos_t             FLOOR_POS = pos_t'(FLOOR_PX);
    localparam pos_t             XMAX_POS  = pos_t'(XMAX_PX);
    localparam ypos_fp_t         FLOOR_FP  = ypos_fp_t'(FLOOR_PX) << FRAC_BITS;
    localparam logic [VEL_W-1:0] GRAV_V    = VEL_W'(GRAVITY);
    localparam logic [VEL_W-1:0] REST_V    = VEL_W'(REST_VEL);

    rect_state_t      r_state;
    logic             r_btn_q;
    logic             r_airborne;
    pos_t             r_x;
    ypos_fp_t         r_y_fp;
    logic [VEL_W-1:0] r_vel;

    logic             w_tick;
    logic             w_click;
    logic [VEL_W:0]   w_vel_sum;
    logic [VEL_W-1:0] w_vel_up;
    logic [VEL_W-1:0] w_vel_bounce;
    logic [VEL_W-1:0] w_vel_dn;
    ypos_fp_t         w_vel_dn_fp;
    ypos_fp_t         w_y_down;
    ypos_fp_t         w_y_follow;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    assign w_click = mouse_left & ~r_btn_q;

    // Falling: the extra carry bit catches overflow so the velocity pins at all-ones
    // instead of wrapping.
    assign w_vel_sum    = {1'b0, r_vel} + {1'b0, GRAV_V};
    assign w_vel_up     = w_vel_sum[VEL_W] ? '1 : w_vel_sum[VEL_W-1:0];
    assign w_vel_bounce = w_vel_up >> BOUNCE_SHIFT;
    assign w_y_down     = r_y_fp + ypos_fp_t'(w_vel_up);

    // Rising: only used when r_vel > GRAVITY, so the subtraction cannot underflow.
    assign w_vel_dn    = r_vel - GRAV_V;
    assign w_vel_dn_fp = ypos_fp_t'(w_vel_dn);

    assign w_y_follow = ypos_fp_t'(clamp_pos(mouse_y_position, FLOOR_POS)) << FRAC_BITS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FOLLOW;
            r_btn_q    <= 1'b0;
            r_airborne <= 1'b0;
            r_x        <= '0;
            r_y_fp     <= '0;
            r_vel      <= '0;
        end else begin
            r_btn_q <= mouse_left;
            case (r_state)
                FOLLOW: begin
                    if (w_click) begin
                        // Position is frozen at its current value on the drop cycle.
                        r_state    <= FALL;
                        r_airborne <= 1'b1;
                        r_vel      <= '0;
                    end else begin
                        r_x    <= clamp_pos(mouse_x_position, XMAX_POS);
                        r_y_fp <= w_y_follow;
                    end
                end
                FALL: begin
                    if (w_click) begin
                        r_state    <= FOLLOW;
                        r_airborne <= 1'b0;
                        r_vel      <= '0;
                    end else if (w_tick) begin
                        if (w_y_down >= FLOOR_FP) begin
                            r_y_fp <= FLOOR_FP;
                            if (w_vel_bounce < REST_V) begin
                                r_state    <= REST;
                                r_airborne <= 1'b0;
                                r_vel      <= '0;
                            end else begin
                                r_state <= RISE;
                                r_vel   <= w_vel_bounce;
                            end
                        end else begin
                            r_y_fp <= w_y_down;
                            r_vel  <= w_vel_up;
                        end
                    end
                end
                RISE: begin
                    if (w_click) begin
                        r_state    <= FOLLOW;
                        r_airborne <= 1'b0;
                        r_vel      <= '0;
                    end else if (w_tick) begin
                        if (r_vel <= GRAV_V) begin
                            // Apex: height holds for this tick, then the fall starts.
                            r_state <= FALL;
                            r_vel   <= '0;
                        end else if (r_y_fp <= w_vel_dn_fp) begin
                            // Ceiling: clamp to the top edge and start falling.
                            r_y_fp  <= '0;
                            r_state <= FALL;
                            r_vel   <= '0;
                        end else begin
                            r_y_fp <= r_y_fp - w_vel_dn_fp;
                            r_vel  <= w_vel_dn;
                        end
                    end
                end
                REST: begin
                    if (w_click) begin
                        r_state    <= FOLLOW;
                        r_airborne <= 1'b0;
                    end else begin
                        r_y_fp <= FLOOR_FP;
                    end
                    r_vel <= '0;
                end
                default: begin
                    r_state    <= FOLLOW;
                    r_airborne <= 1'b0;
                    r_vel      <= '0;
                end
            endcase
        end
    end

    assign xpos      = r_x;
    assign ypos      = r_y_fp[FRAC_BITS +: POS_W];
    assign airborne  = r_airborne;
    assign dbg_state = r_state;
    assign dbg_vel   = r_vel;

endmodule
